// File: rtl/trng_vn_collector.sv
// rtl/trng_vn_collector.sv - TRNG raw-bit collector: synchronizer, von Neumann debias, word packer, repetition-count test
//
// Ports:
//   clk        system clock, rising edge
//   rst_n      asynchronous active-low reset
//   raw_bit    asynchronous raw oscillator bit
//   sample_en  one-cycle sample strobe
//   clr_flags  synchronous pulse clearing overrun, rct_fail and the run counter
//   out_data   packed debiased word (WIDTH bits, first emitted bit in bit 0)
//   out_valid  out_data holds an unconsumed word
//   out_ready  consumer accepts the word
//   overrun    sticky: a completed word was dropped
//   rct_fail   sticky: repetition-count test tripped
module trng_vn_collector #(
    parameter int SYNC_STAGES = 2,
    parameter int WIDTH       = 8,
    parameter int RCT_LIMIT   = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             raw_bit,
    input  logic             sample_en,
    input  logic             clr_flags,
    output logic [WIDTH-1:0] out_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             overrun,
    output logic             rct_fail
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam int RW = $clog2(RCT_LIMIT + 1);

    typedef enum logic {
        PAIR_FIRST  = 1'b0,
        PAIR_SECOND = 1'b1
    } pair_state_t;

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   s;
    pair_state_t            pair_state;
    logic                   pair_a;
    logic                   last_s;
    logic [RW-1:0]          run;
    logic [RW-1:0]          run_next;
    logic [CW-1:0]          bit_cnt;
    logic [WIDTH-1:0]       partial;
    logic [WIDTH-1:0]       word_next;
    logic                   take;
    logic                   emit;
    logic                   word_done;

    assign s = sync_q[SYNC_STAGES-1];

    // clr_flags has priority: a coincident sample is ignored entirely.
    assign take = sample_en & ~clr_flags;

    // Pair (a,s) emits a when the two differ: 10 -> 1, 01 -> 0.
    // Emitted bits are discarded while the health test is tripped, which
    // freezes the partial word and bit counter.
    assign emit      = take && (pair_state == PAIR_SECOND) && (pair_a != s) && !rct_fail;
    assign word_done = emit && (bit_cnt == CW'(WIDTH - 1));

    always_comb begin
        word_next          = partial;
        word_next[bit_cnt] = pair_a;
    end

    // run == 0 marks "no previous sample" (after reset or clr_flags).
    always_comb begin
        run_next = run;
        if (run == '0) begin
            run_next = RW'(1);
        end else if (s != last_s) begin
            run_next = RW'(1);
        end else if (run != RW'(RCT_LIMIT)) begin
            run_next = run + RW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q     <= '0;
            pair_state <= PAIR_FIRST;
            pair_a     <= 1'b0;
            last_s     <= 1'b0;
            run        <= '0;
            bit_cnt    <= '0;
            partial    <= '0;
            out_data   <= '0;
            out_valid  <= 1'b0;
            overrun    <= 1'b0;
            rct_fail   <= 1'b0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], raw_bit};

            // Transfer retires the word; a load later in this block overrides it.
            if (out_valid && out_ready) begin
                out_valid <= 1'b0;
            end

            if (clr_flags) begin
                overrun    <= 1'b0;
                rct_fail   <= 1'b0;
                run        <= '0;
                pair_state <= PAIR_FIRST;
            end else if (take) begin
                run    <= run_next;
                last_s <= s;
                if (run_next == RW'(RCT_LIMIT)) begin
                    rct_fail <= 1'b1;
                end

                case (pair_state)
                    PAIR_FIRST: begin
                        pair_a     <= s;
                        pair_state <= PAIR_SECOND;
                    end
                    default: begin
                        pair_state <= PAIR_FIRST;
                    end
                endcase

                if (emit) begin
                    if (word_done) begin
                        bit_cnt <= '0;
                        partial <= '0;
                        if (!out_valid || out_ready) begin
                            out_data  <= word_next;
                            out_valid <= 1'b1;
                        end else begin
                            overrun <= 1'b1;
                        end
                    end else begin
                        bit_cnt <= bit_cnt + CW'(1);
                        partial <= word_next;
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_trng_vn_collector.sv
// tb/tb_trng_vn_collector.sv - self-checking bench for trng_vn_collector with a queue-based reference model
module tb_trng_vn_collector;

    localparam int SYNC = 2;
    localparam int W    = 8;
    localparam int LIM  = 32;

    logic         clk;
    logic         rst_n;
    logic         raw_bit;
    logic         sample_en;
    logic         clr_flags;
    logic [W-1:0] out_data;
    logic         out_valid;
    logic         out_ready;
    logic         overrun;
    logic         rct_fail;

    trng_vn_collector #(
        .SYNC_STAGES(SYNC),
        .WIDTH      (W),
        .RCT_LIMIT  (LIM)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .raw_bit   (raw_bit),
        .sample_en (sample_en),
        .clr_flags (clr_flags),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .overrun   (overrun),
        .rct_fail  (rct_fail)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Reference model: values the DUT outputs should show after the next edge.
    logic         m_valid;
    logic [W-1:0] m_data;
    logic         m_ovr;
    logic         m_fail;
    int           m_run;
    bit           m_last;
    bit           sq[$];
    bit           pend[$];
    bit           bits[$];

    task automatic model_reset();
        m_valid = 0; m_data = '0; m_ovr = 0; m_fail = 0;
        m_run = 0; m_last = 0;
        sq.delete(); pend.delete(); bits.delete();
        for (int i = 0; i < SYNC; i++) sq.push_back(1'b0);
    endtask

    task automatic model_edge(input bit r, input bit en, input bit clr, input bit rdy);
        bit           s;
        logic         n_valid, n_ovr, n_fail;
        logic [W-1:0] n_data, w;
        s = sq.pop_front();
        sq.push_back(r);
        n_valid = m_valid; n_data = m_data; n_ovr = m_ovr; n_fail = m_fail;
        if (m_valid && rdy) n_valid = 0;
        if (clr) begin
            n_ovr = 0; n_fail = 0; m_run = 0;
            pend.delete();
        end else if (en) begin
            if (m_run == 0 || s != m_last) m_run = 1;
            else m_run = (m_run < LIM) ? m_run + 1 : LIM;
            m_last = s;
            if (m_run == LIM) n_fail = 1;
            pend.push_back(s);
            if (pend.size() == 2) begin
                if (pend[0] != pend[1] && !m_fail) begin
                    bits.push_back(pend[0]);
                    if (bits.size() == W) begin
                        w = '0;
                        for (int i = 0; i < W; i++) w[i] = bits[i];
                        bits.delete();
                        if (!m_valid || rdy) begin
                            n_data  = w;
                            n_valid = 1;
                        end else begin
                            n_ovr = 1;
                        end
                    end
                end
                pend.delete();
            end
        end
        m_valid = n_valid; m_data = n_data; m_ovr = n_ovr; m_fail = n_fail;
    endtask

    int           rises;
    logic [W-1:0] last_rise_data;
    logic         prev_valid;

    task automatic step(input bit r, input bit en, input bit clr, input bit rdy);
        raw_bit = r; sample_en = en; clr_flags = clr; out_ready = rdy;
        if (rst_n) model_edge(r, en, clr, rdy);
        else model_reset();
        @(negedge clk);
        check("out_valid", 32'(out_valid), 32'(m_valid));
        check("out_data", 32'(out_data), 32'(m_data));
        check("overrun", 32'(overrun), 32'(m_ovr));
        check("rct_fail", 32'(rct_fail), 32'(m_fail));
        if (out_valid && !prev_valid) begin
            rises++;
            last_rise_data = out_data;
        end
        prev_valid = out_valid;
    endtask

    // Hold raw_bit long enough to cross the synchronizer, then sample it.
    task automatic take(input bit b, input bit r_idle, input bit r_samp);
        for (int i = 0; i < SYNC; i++) step(b, 0, 0, r_idle);
        step(b, 1, 0, r_samp);
    endtask

    task automatic pair(input bit a, input bit b, input bit rdy);
        take(a, rdy, rdy);
        take(b, rdy, rdy);
    endtask

    task automatic send_word(input logic [W-1:0] w, input bit rdy);
        for (int i = 0; i < W; i++) begin
            if (w[i]) pair(1, 0, rdy);
            else pair(0, 1, rdy);
        end
    endtask

    logic [W-1:0] dbits;
    logic [W-1:0] bword;
    int           thresh;

    initial begin
        rst_n = 0; raw_bit = 0; sample_en = 0; clr_flags = 0; out_ready = 0;
        rises = 0; last_rise_data = '0; prev_valid = 0;
        model_reset();
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            raw_bit = 1'($urandom); sample_en = 1'($urandom);
            clr_flags = 1'($urandom); out_ready = 1'($urandom);
        end
        @(negedge clk);
        check("rst_valid", 32'(out_valid), 0);
        check("rst_data", 32'(out_data), 0);
        check("rst_overrun", 32'(overrun), 0);
        check("rst_rct", 32'(rct_fail), 0);
        rst_n = 1;
        model_reset();
        step(0, 0, 0, 0);

        // Debias and pack, with 00/11 pairs interleaved.
        dbits = 8'b1000_1101;
        rises = 0;
        for (int i = 0; i < W; i++) begin
            if (i > 0) begin
                pair(0, 0, 1);
                pair(1, 1, 1);
            end
            if (dbits[i]) pair(1, 0, 1);
            else pair(0, 1, 1);
        end
        check("debias_latency", 32'(out_valid), 1);
        step(0, 0, 0, 1);
        check("debias_pulses", 32'(rises), 1);
        check("debias_word", 32'(last_rise_data), 32'h8D);

        // Backpressure and overrun.
        send_word(8'hFF, 0);
        send_word(8'h00, 0);
        check("bp_data", 32'(out_data), 32'hFF);
        check("bp_overrun", 32'(overrun), 1);
        step(0, 0, 0, 1);
        check("bp_drain", 32'(out_valid), 0);
        step(0, 0, 1, 0);
        check("bp_clr", 32'(overrun), 0);

        // Completion coinciding with transfer.
        send_word(8'h5A, 0);
        bword = 8'hA5;
        for (int i = 0; i < W - 1; i++) begin
            if (bword[i]) pair(1, 0, 0);
            else pair(0, 1, 0);
        end
        take(1, 0, 0);
        take(0, 0, 1);
        check("b2b_valid", 32'(out_valid), 1);
        check("b2b_data", 32'(out_data), 32'hA5);
        check("b2b_overrun", 32'(overrun), 0);
        step(0, 0, 0, 1);

        // Repetition-count test.
        step(0, 0, 1, 0);
        for (int i = 0; i < LIM - 1; i++) take(1, 0, 0);
        check("rct_before", 32'(rct_fail), 0);
        take(1, 0, 0);
        check("rct_trip", 32'(rct_fail), 1);
        rises = 0;
        send_word(8'hFF, 1);
        check("rct_blocked", 32'(rises), 0);
        step(0, 0, 1, 1);
        check("rct_clr", 32'(rct_fail), 0);
        send_word(8'h3C, 1);
        check("rct_resume_cnt", 32'(rises), 1);
        check("rct_resume_word", 32'(last_rise_data), 32'h3C);
        step(0, 0, 0, 1);

        // Asynchronous reset mid-word with a pending output word.
        send_word(8'h77, 0);
        for (int i = 0; i < 5; i++) pair(1, 0, 0);
        check("ar_pending", 32'(out_valid), 1);
        #2 rst_n = 0;
        #1;
        check("ar_valid", 32'(out_valid), 0);
        check("ar_data", 32'(out_data), 0);
        model_reset();
        prev_valid = 0;
        step(1, 1, 0, 0);
        step(0, 1, 0, 0);
        rst_n = 1;
        step(0, 0, 0, 1);
        rises = 0;
        send_word(8'hC3, 1);
        check("ar_fresh_cnt", 32'(rises), 1);
        check("ar_fresh_word", 32'(last_rise_data), 32'hC3);

        // Randomized traffic with changing bias to exercise the health test.
        for (int seg = 0; seg < 15; seg++) begin
            case (seg % 3)
                0: thresh = 8;
                1: thresh = 15;
                default: thresh = 12;
            endcase
            for (int i = 0; i < 200; i++) begin
                step(bit'(($urandom % 16) < thresh), bit'(($urandom % 4) != 0),
                     bit'(($urandom % 100) == 0), 1'($urandom));
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
